// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - decode stage: scalar/vector register files, immediate extend, D/E pipeline register
// Register files are written at the end of W, with same-cycle write-through into D reads.
module decode_pipe #(
  parameter int N = 32,
  parameter int V = 256,
  parameter int R = 5,
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] InstrD,
  input  logic         ValidD,
  input  logic [1:0]   RegSrcD,
  input  logic [1:0]   ImmSrcD,
  input  logic         StallE,
  input  logic         FlushE,
  input  logic         RegWriteW,
  input  logic [R-1:0] WA3W,
  input  logic [N-1:0] ResultW,
  input  logic [N-1:0] PCPlus8D,
  input  logic         RegWriteVW,
  input  logic [L-1:0] VLaneMaskW,
  input  logic [V-1:0] ResultVW,
  output logic [R-1:0] RA1H,
  output logic [R-1:0] RA2H,
  output logic         ValidE,
  output logic [N-1:0] RD1E,
  output logic [N-1:0] RD2E,
  output logic [V-1:0] VRD1E,
  output logic [V-1:0] VRD2E,
  output logic [R-1:0] WA3E,
  output logic [N-1:0] ExtImmE
);

  localparam int LW      = V / L;
  localparam int DEPTH   = 2 ** R;
  localparam logic [R-1:0] PC_REG = R'(15);

  logic [N-1:0] r_rf  [DEPTH];
  logic [V-1:0] r_vrf [DEPTH];

  logic [R-1:0] w_ra1, w_ra2, w_rd;
  logic [N-1:0] w_rd1, w_rd2, w_ext;
  logic [V-1:0] w_vrd1, w_vrd2;
  logic         w_unused_hi;

  assign w_rd  = InstrD[21 +: R];
  assign w_ra1 = RegSrcD[0] ? PC_REG : InstrD[16 +: R];
  assign w_ra2 = RegSrcD[1] ? w_rd : InstrD[11 +: R];
  assign RA1H  = w_ra1;
  assign RA2H  = w_ra2;
  assign w_unused_hi = &{1'b0, InstrD[N-1:26]};

  // Address 15 reads as PC+8 and never bypasses; other addresses see the in-flight write.
  always_comb begin
    if (w_ra1 == PC_REG)                      w_rd1 = PCPlus8D;
    else if (RegWriteW && (WA3W == w_ra1))    w_rd1 = ResultW;
    else                                      w_rd1 = r_rf[w_ra1];
    if (w_ra2 == PC_REG)                      w_rd2 = PCPlus8D;
    else if (RegWriteW && (WA3W == w_ra2))    w_rd2 = ResultW;
    else                                      w_rd2 = r_rf[w_ra2];
  end

  always_comb begin
    w_vrd1 = r_vrf[w_ra1];
    w_vrd2 = r_vrf[w_ra2];
    for (int i = 0; i < L; i++) begin
      if (RegWriteVW && VLaneMaskW[i] && (WA3W == w_ra1))
        w_vrd1[i*LW +: LW] = ResultVW[i*LW +: LW];
      if (RegWriteVW && VLaneMaskW[i] && (WA3W == w_ra2))
        w_vrd2[i*LW +: LW] = ResultVW[i*LW +: LW];
    end
  end

  always_comb begin
    case (ImmSrcD)
      2'b00:   w_ext = {{(N-16){InstrD[15]}}, InstrD[15:0]};
      2'b01:   w_ext = {{(N-16){1'b0}}, InstrD[15:0]};
      2'b10:   w_ext = {{(N-8){1'b0}}, InstrD[10:3]};
      default: w_ext = {{(N-26){InstrD[25]}}, InstrD[25:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) r_rf[a] <= '0;
    end else if (RegWriteW) begin
      r_rf[WA3W] <= ResultW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) r_vrf[a] <= '0;
    end else if (RegWriteVW) begin
      for (int i = 0; i < L; i++)
        if (VLaneMaskW[i]) r_vrf[WA3W][i*LW +: LW] <= ResultVW[i*LW +: LW];
    end
  end

  // Flush beats stall; a stalled register keeps its stale operands on purpose.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ValidE  <= 1'b0;
      RD1E    <= '0;
      RD2E    <= '0;
      VRD1E   <= '0;
      VRD2E   <= '0;
      WA3E    <= '0;
      ExtImmE <= '0;
    end else if (FlushE) begin
      ValidE  <= 1'b0;
      RD1E    <= '0;
      RD2E    <= '0;
      VRD1E   <= '0;
      VRD2E   <= '0;
      WA3E    <= '0;
      ExtImmE <= '0;
    end else if (!StallE) begin
      ValidE  <= ValidD;
      RD1E    <= w_rd1;
      RD2E    <= w_rd2;
      VRD1E   <= w_vrd1;
      VRD2E   <= w_vrd2;
      WA3E    <= w_rd;
      ExtImmE <= w_ext;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - directed self-checking bench for decode_pipe
module tb_decode_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  InstrD;
  logic         ValidD;
  logic [1:0]   RegSrcD, ImmSrcD;
  logic         StallE, FlushE;
  logic         RegWriteW;
  logic [4:0]   WA3W;
  logic [31:0]  ResultW, PCPlus8D;
  logic         RegWriteVW;
  logic [7:0]   VLaneMaskW;
  logic [255:0] ResultVW;
  logic [4:0]   RA1H, RA2H, WA3E;
  logic         ValidE;
  logic [31:0]  RD1E, RD2E, ExtImmE;
  logic [255:0] VRD1E, VRD2E;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] ALL1   = '1;
  localparam logic [255:0] LANE0Z = {{224{1'b1}}, 32'h0};

  decode_pipe dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .RegSrcD(RegSrcD),
    .ImmSrcD(ImmSrcD), .StallE(StallE), .FlushE(FlushE), .RegWriteW(RegWriteW),
    .WA3W(WA3W), .ResultW(ResultW), .PCPlus8D(PCPlus8D), .RegWriteVW(RegWriteVW),
    .VLaneMaskW(VLaneMaskW), .ResultVW(ResultVW), .RA1H(RA1H), .RA2H(RA2H),
    .ValidE(ValidE), .RD1E(RD1E), .RD2E(RD2E), .VRD1E(VRD1E), .VRD2E(VRD2E),
    .WA3E(WA3E), .ExtImmE(ExtImmE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    InstrD = '0; ValidD = 1'b0; RegSrcD = 2'b00; ImmSrcD = 2'b00;
    StallE = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0; WA3W = '0; ResultW = '0;
    PCPlus8D = 32'h100; RegWriteVW = 1'b0; VLaneMaskW = '0; ResultVW = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #12;
    check("reset_valid", ValidE, 0);
    check("reset_rd1", RD1E, 0);
    check("reset_vrd1", VRD1E, 0);
    @(negedge clk); rst = 1'b1;

    // write r3 = 0xAA
    RegWriteW = 1'b1; WA3W = 5'd3; ResultW = 32'hAA;
    step();
    RegWriteW = 1'b0;
    InstrD = 32'h0003_7800; ValidD = 1'b1;
    #1;
    check("ra1h", RA1H, 3);
    check("ra2h", RA2H, 15);
    step();
    check("r3_read", RD1E, 32'hAA);
    check("pc_read", RD2E, 32'h100);
    check("valid_e", ValidE, 1);
    check("ext_plain", ExtImmE, 32'h7800);

    // scalar bypass r5 = 0x1234
    RegWriteW = 1'b1; WA3W = 5'd5; ResultW = 32'h1234; InstrD = 32'h0005_1800;
    step();
    check("bypass_r5", RD1E, 32'h1234);
    check("r3_rt", RD2E, 32'hAA);
    RegWriteW = 1'b0;
    step();
    check("stored_r5", RD1E, 32'h1234);

    // write to 15 invisible, RA1 forced to 15
    RegWriteW = 1'b1; WA3W = 5'd15; ResultW = 32'hDEAD; RegSrcD = 2'b01;
    InstrD = 32'h0000_2800; PCPlus8D = 32'h200;
    #1;
    check("ra1h_15", RA1H, 15);
    step();
    check("r15_nobypass", RD1E, 32'h200);
    check("r15_rt_r5", RD2E, 32'h1234);
    RegWriteW = 1'b0; PCPlus8D = 32'h100;

    // RA2 = rd
    RegSrcD = 2'b10; InstrD = 32'h0060_0000;
    step();
    check("ra2_rd", RD2E, 32'hAA);
    check("wa3e", WA3E, 3);
    check("r0_read", RD1E, 0);
    RegSrcD = 2'b00;

    // vector v2 all ones, then lane 0 cleared with same-cycle read
    RegWriteVW = 1'b1; WA3W = 5'd2; VLaneMaskW = 8'hFF; ResultVW = ALL1; InstrD = '0;
    step();
    VLaneMaskW = 8'h01; ResultVW = '0; InstrD = 32'h0002_0000;
    step();
    check("vbypass", VRD1E, LANE0Z);
    check("vrt0", VRD2E, 0);
    RegWriteVW = 1'b0;
    step();
    check("vstored", VRD1E, LANE0Z);

    // immediate extension
    ImmSrcD = 2'b00; InstrD = 32'h0000_8000; step(); check("imm_sext16", ExtImmE, 32'hFFFF_8000);
    ImmSrcD = 2'b01; step(); check("imm_zext16", ExtImmE, 32'h0000_8000);
    ImmSrcD = 2'b10; InstrD = 32'h0000_07F8; step(); check("imm_zext8", ExtImmE, 32'hFF);
    ImmSrcD = 2'b11; InstrD = 32'h0200_0000; step(); check("imm_sext26", ExtImmE, 32'hFE00_0000);
    ImmSrcD = 2'b00;

    // flush beats stall
    StallE = 1'b1; FlushE = 1'b1; ValidD = 1'b1; InstrD = 32'h0003_7800;
    step();
    check("flush_valid", ValidE, 0);
    check("flush_rd1", RD1E, 0);
    check("flush_imm", ExtImmE, 0);
    StallE = 1'b0; FlushE = 1'b0;
    step();
    check("load_rd1", RD1E, 32'hAA);

    // stall 3 cycles while r3 is rewritten
    StallE = 1'b1; InstrD = 32'h0005_0000; ValidD = 1'b0;
    RegWriteW = 1'b1; WA3W = 5'd3; ResultW = 32'h55;
    step();
    RegWriteW = 1'b0;
    for (int i = 0; i < 2; i++) step();
    check("stall_rd1", RD1E, 32'hAA);
    check("stall_valid", ValidE, 1);
    check("stall_imm", ExtImmE, 32'h7800);
    StallE = 1'b0; InstrD = 32'h0003_0000; ValidD = 1'b1;
    step();
    check("write_in_stall", RD1E, 32'h55);

    // async reset mid-stall
    StallE = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_valid", ValidE, 0);
    check("async_rd1", RD1E, 0);
    RegWriteW = 1'b1; WA3W = 5'd3; ResultW = 32'h77;
    step();
    @(negedge clk);
    rst = 1'b1; RegWriteW = 1'b0; StallE = 1'b0;
    InstrD = 32'h0003_1000;
    step();
    check("post_rst_r3", RD1E, 0);
    check("post_rst_v2", VRD2E, 0);
    check("post_rst_valid", ValidE, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
